// File: rtl/player_shot_ctl.sv
// Player projectile sequencer: launches one shot from the ship's muzzle on a fire press,
// moves it up once per frame, retires it on hit or screen exit, then runs a reload cooldown.
module player_shot_ctl #(
  parameter int PLAYER_Y        = 736,
  parameter int MUZZLE_OFS      = 11,
  parameter int BULLET_H        = 8,
  parameter int BULLET_SPEED    = 8,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int HOR_PIXELS      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        button_fire,
  input  logic [11:0] player_xpos,
  input  logic        hit,
  output logic        bullet_active,
  output logic [11:0] bullet_xpos,
  output logic [11:0] bullet_ypos,
  output logic        shot_fired,
  output logic        ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_FLY, ST_COOLDOWN} state_t;

  localparam logic [11:0] Y_RESET  = 12'(PLAYER_Y);
  localparam logic [11:0] Y_LAUNCH = 12'(PLAYER_Y - BULLET_H);
  localparam logic [11:0] SPEED    = 12'(BULLET_SPEED);
  localparam logic [12:0] X_MAX    = 13'(HOR_PIXELS - 1);
  localparam logic [12:0] X_OFS    = 13'(MUZZLE_OFS);
  localparam logic [7:0]  CD_LOAD  = 8'(COOLDOWN_FRAMES);

  state_t      state, state_nxt;
  logic        active_nxt, shot_nxt;
  logic [11:0] x_nxt, y_nxt;
  logic        fire_pending, pending_nxt;
  logic [7:0]  cd_cnt, cd_nxt;
  logic        button_fire_q;
  logic        fire_edge;
  logic [12:0] launch_sum;
  logic [11:0] launch_x;

  assign fire_edge  = button_fire & ~button_fire_q;
  // Sum at 13 bits so a ship near the right edge clamps instead of wrapping to the left.
  assign launch_sum = {1'b0, player_xpos} + X_OFS;
  assign launch_x   = (launch_sum > X_MAX) ? X_MAX[11:0] : launch_sum[11:0];

  // NOTE: every next-state variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    active_nxt  = bullet_active;
    x_nxt       = bullet_xpos;
    y_nxt       = bullet_ypos;
    shot_nxt    = 1'b0;
    pending_nxt = fire_pending;
    cd_nxt      = cd_cnt;

    case (state)
      ST_IDLE: begin
        if (frame_tick && (fire_pending || fire_edge)) begin
          state_nxt   = ST_FLY;
          pending_nxt = 1'b0;
          active_nxt  = 1'b1;
          shot_nxt    = 1'b1;
          x_nxt       = launch_x;
          y_nxt       = Y_LAUNCH;
        end else if (fire_edge) begin
          pending_nxt = 1'b1;
        end
      end

      ST_FLY: begin
        pending_nxt = 1'b0;
        // A hit outranks movement even when it lands on the frame tick.
        if (hit) begin
          state_nxt  = ST_COOLDOWN;
          active_nxt = 1'b0;
          cd_nxt     = CD_LOAD;
        end else if (frame_tick) begin
          if (bullet_ypos < SPEED) begin
            state_nxt  = ST_COOLDOWN;
            active_nxt = 1'b0;
            cd_nxt     = CD_LOAD;
          end else begin
            y_nxt = bullet_ypos - SPEED;
          end
        end
      end

      ST_COOLDOWN: begin
        pending_nxt = 1'b0;
        if (cd_cnt == 8'd0) begin
          state_nxt = ST_IDLE;
        end else if (frame_tick) begin
          cd_nxt = cd_cnt - 8'd1;
        end
      end

      default: begin
        state_nxt  = ST_IDLE;
        active_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bullet_active <= 1'b0;
      bullet_xpos   <= 12'd0;
      bullet_ypos   <= Y_RESET;
      shot_fired    <= 1'b0;
      ready         <= 1'b1;
      fire_pending  <= 1'b0;
      cd_cnt        <= 8'd0;
      button_fire_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      bullet_active <= active_nxt;
      bullet_xpos   <= x_nxt;
      bullet_ypos   <= y_nxt;
      shot_fired    <= shot_nxt;
      ready         <= (state_nxt == ST_IDLE);
      fire_pending  <= pending_nxt;
      cd_cnt        <= cd_nxt;
      button_fire_q <= button_fire;
    end
  end

endmodule
